// File: rtl/inst_fetch_unit_pkg.sv
// Constants and types for the instruction-fetch stage.
// The decode stage and register file also use these constants.
package inst_fetch_unit_pkg;

    localparam int INST_W = 32;
    localparam int PC_INC = 4;
    localparam int QDEPTH = 2;

    typedef struct packed {
        logic [INST_W-1:0] code;
        logic [INST_W-1:0] pc;
    } q_entry_t;

    // Boot program image: four R-type ops at the start, then distinct filler words.
    function automatic logic [INST_W-1:0] rom_image(input int unsigned idx);
        case (idx)
            0:       rom_image = 32'h0022_1820;
            1:       rom_image = 32'h0022_1822;
            2:       rom_image = 32'h0022_1824;
            3:       rom_image = 32'h0022_1825;
            default: rom_image = 32'h0040_0000 + idx * 32'h0000_0801;
        endcase
    endfunction

endpackage

// File: rtl/inst_rom.sv
// Word-addressed instruction ROM with one-cycle registered read.
// An empty INIT_FILE name yields a blank (all-zero) ROM.
module inst_rom
    import inst_fetch_unit_pkg::*;
#(
    parameter int    AW        = 6,
    parameter string INIT_FILE = "inst.coe"
) (
    input  logic              clka,
    input  logic [AW-1:0]     addra,
    output logic [INST_W-1:0] douta
);

    localparam bit HAS_IMAGE = (INIT_FILE != "");

    always_ff @(posedge clka) begin
        douta <= HAS_IMAGE ? rom_image(32'(addra)) : '0;
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: PC, ROM read, 2-entry prefetch queue with valid/ready
// output, and redirect flush.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int          AW        = 6,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter string       INIT_FILE = "inst.coe"
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_code,
    output logic [31:0] inst_pc,
    output logic [31:0] fetch_cnt
);

    logic [31:0]       pc;
    logic [31:0]       tag_pc;
    logic              inflight;
    logic              run;
    logic [1:0]        count;
    q_entry_t          head;
    q_entry_t          tail;
    q_entry_t          incoming;
    logic [INST_W-1:0] rom_data;
    logic [2:0]        occ;
    logic              pop;
    logic              push;
    logic              issue;

    inst_rom #(
        .AW        (AW),
        .INIT_FILE (INIT_FILE)
    ) u_rom (
        .clka  (clk),
        .addra (pc[AW+1:2]),
        .douta (rom_data)
    );

    // Empty slots are kept at zero, so the head reads 0 whenever the queue is empty.
    assign inst_valid = (count != 2'd0);
    assign inst_code  = head.code;
    assign inst_pc    = head.pc;

    assign pop      = inst_valid & inst_ready;
    assign push     = inflight;
    assign incoming = '{code: rom_data, pc: tag_pc};

    // Slots committed after this edge; an in-flight read already owns one.
    assign occ   = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    // run delays the first issue by one cycle after reset release.
    assign issue = run & fetch_en & ~redir_valid & (occ < 3'(QDEPTH));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run       <= 1'b0;
            pc        <= RESET_PC;
            tag_pc    <= '0;
            inflight  <= 1'b0;
            count     <= '0;
            head      <= '0;
            tail      <= '0;
            fetch_cnt <= '0;
        end else begin
            run <= 1'b1;
            if (pop) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (redir_valid) begin
                // The word returning from the ROM this cycle is dropped with the queue.
                pc       <= redir_pc & ~32'h0000_0003;
                inflight <= 1'b0;
                count    <= '0;
                head     <= '0;
                tail     <= '0;
            end else begin
                inflight <= issue;
                if (issue) begin
                    tag_pc <= pc;
                    pc     <= pc + 32'(PC_INC);
                end
                case ({push, pop})
                    2'b10: begin
                        if (count == 2'd0) begin
                            head <= incoming;
                        end else begin
                            tail <= incoming;
                        end
                        count <= count + 2'd1;
                    end
                    2'b01: begin
                        head  <= tail;
                        tail  <= '0;
                        count <= count - 2'd1;
                    end
                    2'b11: begin
                        if (count == 2'd1) begin
                            head <= incoming;
                        end else begin
                            head <= tail;
                            tail <= incoming;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Testbench for inst_fetch_unit: directed scenarios plus randomized traffic
// against a stream model (expected next PC, ROM image table, handoff count).
module tb_inst_fetch_unit;

    localparam int AW = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_en = 1'b0;
    logic        redir_valid = 1'b0;
    logic [31:0] redir_pc = 32'h0;
    logic        inst_ready = 1'b0;
    logic        inst_valid;
    logic [31:0] inst_code;
    logic [31:0] inst_pc;
    logic [31:0] fetch_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_pc  = 32'h0;
    logic [31:0] exp_cnt = 32'h0;

    always #5 clk = ~clk;

    inst_fetch_unit #(
        .AW        (AW),
        .RESET_PC  (32'h0000_0000),
        .INIT_FILE ("inst.coe")
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_en    (fetch_en),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst_code   (inst_code),
        .inst_pc     (inst_pc),
        .fetch_cnt   (fetch_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expected ROM contents, indexed by the word-within-ROM of a byte address.
    function automatic logic [31:0] ref_word(input logic [31:0] byte_addr);
        logic [5:0] idx;
        idx = byte_addr[7:2];
        case (idx)
            6'd0:    ref_word = 32'h0022_1820;
            6'd1:    ref_word = 32'h0022_1822;
            6'd2:    ref_word = 32'h0022_1824;
            6'd3:    ref_word = 32'h0022_1825;
            default: ref_word = 32'h0040_0000 + 32'(idx) * 32'h0000_0801;
        endcase
    endfunction

    task automatic check_head(input string tag);
        if (inst_valid) begin
            check({tag, "_pc"}, inst_pc, exp_pc);
            check({tag, "_code"}, inst_code, ref_word(exp_pc));
        end else begin
            check({tag, "_empty_pc"}, inst_pc, 32'h0);
            check({tag, "_empty_code"}, inst_code, 32'h0);
        end
    endtask

    // One clock: apply inputs, update the model for what the edge does, then check.
    task automatic cycle(input logic en, input logic rdy, input logic rv,
                         input logic [31:0] rpc, output logic popped);
        logic hold;
        fetch_en    = en;
        inst_ready  = rdy;
        redir_valid = rv;
        redir_pc    = rpc;
        popped = inst_valid & rdy;
        hold   = inst_valid & ~rdy & ~rv;
        if (popped) begin
            exp_pc  = exp_pc + 32'd4;
            exp_cnt = exp_cnt + 32'd1;
        end
        if (rv) exp_pc = rpc & ~32'h3;
        @(posedge clk);
        #1;
        check("fetch_cnt", fetch_cnt, exp_cnt);
        check("no_overflow", {31'b0, dut.count == 2'd3}, 32'h0);
        check_head("head");
        if (rv) check("redir_flush", {31'b0, inst_valid}, 32'h0);
        if (hold) check("hold_valid", {31'b0, inst_valid}, 32'h1);
    endtask

    task automatic run_n(input logic en, input logic rdy, input int n);
        logic p;
        for (int i = 0; i < n; i++) cycle(en, rdy, 1'b0, 32'h0, p);
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b0;
        #1;
        check("arst_valid", {31'b0, inst_valid}, 32'h0);
        check("arst_cnt", fetch_cnt, 32'h0);
        check("arst_code", inst_code, 32'h0);
        check("arst_pc", inst_pc, 32'h0);
        fetch_en    = 1'b0;
        inst_ready  = 1'b0;
        redir_valid = 1'b0;
        exp_pc      = 32'h0;
        exp_cnt     = 32'h0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic p;
        int   n;

        #12;
        check("rst_valid", {31'b0, inst_valid}, 32'h0);
        check("rst_code", inst_code, 32'h0);
        check("rst_pc", inst_pc, 32'h0);
        check("rst_cnt", fetch_cnt, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Latency and back-to-back streaming from reset
        cycle(1'b1, 1'b1, 1'b0, 32'h0, p);
        check("t1_lat1", {31'b0, inst_valid}, 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 32'h0, p);
        check("t1_lat2", {31'b0, inst_valid}, 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 32'h0, p);
        check("t1_lat3", {31'b0, inst_valid}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            check("t1_stream_valid", {31'b0, inst_valid}, 32'h1);
            check("t1_stream_pc", inst_pc, 32'(4 * i));
            cycle(1'b1, 1'b1, 1'b0, 32'h0, p);
        end
        check("t1_cnt4", fetch_cnt, 32'd4);

        // Backpressure fills the queue and holds the head
        do_reset();
        run_n(1'b1, 1'b0, 3);
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_code", inst_code, 32'h0022_1820);
            cycle(1'b1, 1'b0, 1'b0, 32'h0, p);
        end
        check("t2_full", {30'b0, dut.count}, 32'd2);
        for (int i = 0; i < 3; i++) begin
            check("t2_order_pc", inst_pc, 32'(4 * i));
            cycle(1'b1, 1'b1, 1'b0, 32'h0, p);
        end

        // Redirect to a misaligned target
        run_n(1'b1, 1'b1, 3);
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_0013, p);
        cycle(1'b1, 1'b1, 1'b0, 32'h0, p);
        check("t3_gap", {31'b0, inst_valid}, 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 32'h0, p);
        check("t3_valid", {31'b0, inst_valid}, 32'h1);
        check("t3_pc", inst_pc, 32'h0000_0010);
        run_n(1'b1, 1'b1, 4);

        // ROM index wrap and 32-bit PC wrap
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_00FC, p);
        run_n(1'b1, 1'b1, 2);
        check("t4_pc63", inst_pc, 32'h0000_00FC);
        check("t4_code63", inst_code, ref_word(32'h0000_00FC));
        cycle(1'b1, 1'b1, 1'b0, 32'h0, p);
        check("t4_pc100", inst_pc, 32'h0000_0100);
        check("t4_code0", inst_code, 32'h0022_1820);
        cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, p);
        run_n(1'b1, 1'b1, 2);
        check("t4_pc_top", inst_pc, 32'hFFFF_FFFC);
        cycle(1'b1, 1'b1, 1'b0, 32'h0, p);
        check("t4_pc_wrap", inst_pc, 32'h0000_0000);
        run_n(1'b1, 1'b1, 3);

        // fetch_en low: queue drains, then resumes sequentially
        n = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 32'h0, p);
            if (p) n++;
        end
        check("t5_drain_le2", {31'b0, n <= 2}, 32'h1);
        check("t5_idle", {31'b0, inst_valid}, 32'h0);
        run_n(1'b1, 1'b1, 6);

        // Asynchronous reset with a full queue
        run_n(1'b1, 1'b0, 4);
        check("t6_full", {30'b0, dut.count}, 32'd2);
        do_reset();
        run_n(1'b1, 1'b1, 3);
        check("t6_restart_valid", {31'b0, inst_valid}, 32'h1);
        check("t6_restart_pc", inst_pc, 32'h0);

        // Randomized traffic against the stream model
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 6,
                  $urandom_range(0, 24) == 0, $urandom, p);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
Instruction-fetch stage that feeds the single-cycle R-type datapath (decode, register file, ALU) with 32-bit instruction words.
- Holds the PC and reads a word-addressed instruction ROM with 1-cycle synchronous read.
- Buffers fetched words in a 2-entry prefetch queue and presents them downstream through a valid/ready handshake.
- Accepts a redirect (new PC) that flushes all fetched-but-unconsumed work.

Parameters:
AW, 6, ROM address width in words (ROM depth = 2^AW).
RESET_PC, 32'h0000_0000, PC value loaded at reset.
INIT_FILE, "inst.coe", ROM initialisation image passed to the ROM sub-module.

Ports:
clk  in  1  single clock; all state updates on rising edge.
rst  in  1  asynchronous active-low reset.
fetch_en  in  1  high permits new ROM reads; low freezes PC and issue, queue still drains.
redir_valid  in  1  redirect request, one-cycle pulse.
redir_pc  in  32  redirect target; bits [1:0] forced to 00.
inst_valid  out  1  queue head holds a valid instruction.
inst_ready  in  1  downstream accepts the head this cycle.
inst_code  out  32  instruction word at queue head.
inst_pc  out  32  byte address of inst_code.
fetch_cnt  out  32  count of instructions handed downstream (valid&ready).

Behaviour:
- Reset (rst=0, asynchronous) clears all state:
  - pc=RESET_PC, queue count=0, in-flight flag=0, fetch_cnt=0.
  - inst_valid=0, inst_code=0, inst_pc=0.
- Queue outputs:
  - inst_code/inst_pc are driven from queue head registers.
  - When empty they hold 32'h0000_0000.
- Transfer: pop = inst_valid & inst_ready. Changing inst_code/inst_pc while inst_valid=1 and inst_ready=0 is forbidden.
- Issue rule:
  - issue = fetch_en & ~redir_valid & (count + inflight - pop < 2).
  - On issue: ROM address = pc[AW+1:2]; {pc} captured as tag; pc <= pc+4; inflight <= 1.
- ROM return: the word returns the next cycle and is pushed into the queue together with its tag PC.
- Latency:
  - First issue in the cycle after reset release.
  - inst_valid rises 2 cycles after that issue edge. Cycle 1: issue/ROM read. Cycle 2: push. Head is visible after the push edge.
- Throughput: 1 instruction/cycle when inst_ready stays high.
- Simultaneous push and pop: count unchanged; head advances to the next entry. Push into an empty queue with a pop in the same cycle is not possible, because pop requires a valid head.
- Full (count=2): issue is blocked unless a pop occurs the same cycle and inflight=0. Overflow must never occur; the bench asserts this.
- Redirect (highest priority): on redir_valid=1 at an edge:
  - count <= 0 and inflight <= 0; the returning ROM word is discarded.
  - pc <= {redir_pc[31:2],2'b00}.
  - A pop in that same cycle still counts in fetch_cnt.
  - inst_valid=0 from the next cycle.
  - Issue resumes the cycle after the redirect.
- Wrap-around:
  - pc wraps modulo 2^32.
  - ROM index uses only pc[AW+1:2], so fetch wraps to word 0 after word 2^AW-1 while inst_pc keeps the full 32-bit value.
- fetch_cnt increments by 1 per pop and wraps modulo 2^32.
- fetch_en=0 mid-stream: an in-flight read still completes and is pushed; the queue drains normally.
- Reset asserted mid-operation: everything returns to reset values immediately, independent of clk.

Decomposition:
- Shared package/header: constants INST_W=32, PC_INC=4, QDEPTH=2. These are shared with the decode stage and register file.
- One sub-module, inst_rom: synchronous-read ROM (clka, addra[AW-1:0], douta[31:0]) initialised from INIT_FILE. It maps to block RAM.
- The queue and PC logic stay in inst_fetch_unit.

Test Plan:
1. Reset release, ROM words 0..3 = 32'h0022_1820, 32'h0022_1822, 32'h0022_1824, 32'h0022_1825; inst_ready=1 → inst_valid rises on 3rd edge after release; inst_pc sequence 0,4,8,12 on consecutive cycles; fetch_cnt=4 after 4 pops.
2. Backpressure: inst_ready=0 for 5 cycles after first valid → inst_code held at 32'h0022_1820, count saturates at 2, no further issue; ready=1 → words 0,1,2 delivered in order, none lost or duplicated.
3. Redirect: while ready=1, pulse redir_valid with redir_pc=32'h0000_0013 → next valid inst_pc=32'h0000_0010; queued words at old PCs never appear.
4. Wrap: AW=6, redirect to 32'h0000_00FC → delivers word 63 (inst_pc=0xFC), then word 0 with inst_pc=32'h0000_0100.
5. fetch_en toggle: fetch_en=0 for 4 cycles with ready=1 → at most 2 further instructions (queued plus in-flight) are delivered, then inst_valid=0; re-enable → resumes at the next sequential PC.
6. Async reset mid-stream: drop rst between clk edges with count=2 → inst_valid=0, fetch_cnt=0 immediately; after release fetch restarts at RESET_PC.
